// File: rtl/sklansky_addsub_pipe.sv
// sklansky_addsub_pipe
//   Pipelined N-bit adder/subtractor built on a Sklansky parallel-prefix
//   carry tree. A register group is placed after every PIPE_EVERY prefix
//   levels (PIPE_EVERY = 0 keeps the whole tree combinational). The final
//   stage derives the carries, the sum and the flags, and registers them
//   together.
//
// Ports
//   CLOCK_50   in   sole clock, rising edge
//   reset      in   synchronous, active-high; clears every stage valid bit
//                   and all outputs
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept a beat this cycle
//   a, b       in   N-bit operands
//   cin        in   carry-in (add) / borrow-in (subtract)
//   op         in   0 = a + b + cin, 1 = a - b - cin
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the result
//   sum        out  N-bit result (modulo 2^N)
//   cout       out  carry out of bit N-1 (subtract: 1 = no borrow)
//   overflow   out  signed overflow, C[N] ^ C[N-1]
//   zero       out  sum == 0
//   negative   out  sum[N-1]
//
// Handshake: a beat is accepted on a rising edge where in_valid & in_ready,
// and a result is consumed on a rising edge where out_valid & out_ready.
// advance = ~out_valid | out_ready moves every stage at once, bubbles
// included; in_ready is advance itself, so a stalled output freezes the
// whole pipe and in_ready drops in the same cycle.
module sklansky_addsub_pipe #(
    parameter int N          = 8,
    parameter int PIPE_EVERY = 1
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int LOG2N  = $clog2(N);
    localparam int NG     = (PIPE_EVERY == 0) ? 0
                          : (LOG2N + PIPE_EVERY - 1) / PIPE_EVERY;
    // Storage is declared with at least one entry so that the
    // PIPE_EVERY = 0 build still has legal (reset-only) arrays.
    localparam int NGR    = (NG == 0) ? 1 : NG;
    localparam int PE_DIV = (PIPE_EVERY == 0) ? 1 : PIPE_EVERY;
    localparam int LAST   = (NG == 0) ? 0 : NG - 1;

    // Prefix level at which register group s (0-based) is captured.
    function automatic int group_end(input int s);
        int e;
        e = (s + 1) * PE_DIV;
        return (e > LOG2N) ? LOG2N : e;
    endfunction

    logic         advance;
    logic [N-1:0] b_eff;
    logic         c0_in;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + ~cin, so a borrow-in removes the implicit +1.
    assign b_eff = op ? ~b : b;
    assign c0_in = op ? ~cin : cin;

    // Register group storage: group-generate/propagate after the group's
    // last level, plus the level-0 propagate, c0 and valid that ride along.
    logic [N-1:0] stg_g  [0:NGR-1];
    logic [N-1:0] stg_p  [0:NGR-1];
    logic [N-1:0] stg_p0 [0:NGR-1];
    logic         stg_c0 [0:NGR-1];
    logic         stg_v  [0:NGR-1];

    // Prefix tree. lg/lp[k] is the (G, P) vector after level k. The first
    // level of each group after the first reads the previous group's
    // register instead of the combinational level below it.
    logic [N-1:0] lg [0:LOG2N];
    logic [N-1:0] lp [0:LOG2N];
    logic [N-1:0] src_g;
    logic [N-1:0] src_p;

    always_comb begin : prefix_tree
        int si;
        int j;
        src_g = '0;
        src_p = '0;
        lg[0] = a & b_eff;
        lp[0] = a ^ b_eff;
        for (int k = 1; k <= LOG2N; k++) begin
            src_g = lg[k-1];
            src_p = lp[k-1];
            if (PIPE_EVERY != 0 && k > 1 && ((k - 1) % PE_DIV) == 0) begin
                si = (k - 1) / PE_DIV - 1;
                // Keeps the index legal in builds where this branch is dead.
                if (si >= NGR) si = NGR - 1;
                src_g = stg_g[si];
                src_p = stg_p[si];
            end
            lg[k] = src_g;
            lp[k] = src_p;
            for (int i = 0; i < N; i++) begin
                if (((i >> (k - 1)) & 1) == 1) begin
                    // Combine with the top node of the adjacent lower block.
                    j = ((i >> (k - 1)) << (k - 1)) - 1;
                    lg[k][i] = src_g[i] | (src_p[i] & src_g[j]);
                    lp[k][i] = src_p[i] & src_p[j];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int s = 0; s < NGR; s++) begin
                stg_g[s]  <= '0;
                stg_p[s]  <= '0;
                stg_p0[s] <= '0;
                stg_c0[s] <= 1'b0;
                stg_v[s]  <= 1'b0;
            end
        end else if (advance) begin
            if (NG > 0) begin
                // The level-0 register is folded into the first group.
                stg_g[0]  <= lg[group_end(0)];
                stg_p[0]  <= lp[group_end(0)];
                stg_p0[0] <= lp[0];
                stg_c0[0] <= c0_in;
                stg_v[0]  <= in_valid;
            end
            for (int s = 1; s < NG; s++) begin
                stg_g[s]  <= lg[group_end(s)];
                stg_p[s]  <= lp[group_end(s)];
                stg_p0[s] <= stg_p0[s-1];
                stg_c0[s] <= stg_c0[s-1];
                stg_v[s]  <= stg_v[s-1];
            end
        end
    end

    // Final stage source: straight from the tree when nothing is pipelined.
    logic [N-1:0] f_g;
    logic [N-1:0] f_p;
    logic [N-1:0] f_p0;
    logic         f_c0;
    logic         f_v;

    assign f_g  = (NG == 0) ? lg[LOG2N] : stg_g[LAST];
    assign f_p  = (NG == 0) ? lp[LOG2N] : stg_p[LAST];
    assign f_p0 = (NG == 0) ? lp[0]     : stg_p0[LAST];
    assign f_c0 = (NG == 0) ? c0_in     : stg_c0[LAST];
    assign f_v  = (NG == 0) ? in_valid  : stg_v[LAST];

    // After the last level every node spans bits [i:0], so the carry into
    // bit i+1 only needs c0 folded in.
    logic [N:0]   carry;
    logic [N-1:0] res_sum;

    always_comb begin
        carry    = '0;
        carry[0] = f_c0;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = f_g[i] | (f_p[i] & f_c0);
        end
        res_sum = f_p0 ^ carry[N-1:0];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (advance) begin
            out_valid <= f_v;
            sum       <= res_sum;
            cout      <= carry[N];
            overflow  <= carry[N] ^ carry[N-1];
            zero      <= (res_sum == '0);
            negative  <= res_sum[N-1];
        end
    end

endmodule
